// File: rtl/issue_pkg.sv
// Shared sizes, types and small helpers for the FU issue scheduler.
package issue_pkg;
  localparam int unsigned RS_SIZE  = 64;
  localparam int unsigned NUM_FU   = 3;
  localparam int unsigned RS_IDX_W = 6;
  localparam int unsigned ALU_LAT  = 1;
  localparam int unsigned LS_LAT   = 3;
  localparam int unsigned BUSY_W   = 2;

  typedef logic [1:0]          fu_id_t;
  typedef logic [RS_IDX_W-1:0] rs_idx_t;
  typedef logic [BUSY_W-1:0]   busy_t;

  // FU visited at position ofs of the rotating FU order
  function automatic fu_id_t fu_add(input fu_id_t base, input int unsigned ofs);
    return fu_id_t'((32'(base) + ofs) % NUM_FU);
  endfunction

  // Remaining busy cycles after a grant of the given op class
  function automatic busy_t busy_load(input logic is_ls);
    return is_ls ? busy_t'(LS_LAT - 1) : busy_t'(ALU_LAT - 1);
  endfunction
endpackage

// File: rtl/rr_find_first.sv
// Wrapping find-first: first set bit of (vec & ~excl) scanning upward from start.
module rr_find_first
  import issue_pkg::*;
(
  input  logic [RS_SIZE-1:0] i_vec,
  input  rs_idx_t            i_start,
  input  logic [RS_SIZE-1:0] i_excl,
  output logic               o_found,
  output rs_idx_t            o_idx
);
  logic [RS_SIZE-1:0] w_cand;

  assign w_cand = i_vec & ~i_excl;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!o_found && w_cand[rs_idx_t'((32'(i_start) + i) % RS_SIZE)]) begin
        o_found = 1'b1;
        o_idx   = rs_idx_t'((32'(i_start) + i) % RS_SIZE);
      end
    end
  end
endmodule

// File: rtl/fu_issue_scheduler.sv
// Select/issue arbiter: grants up to NUM_FU ready RS entries per cycle, one LS max.
// Optional perf counters (perf_grants, perf_stall) under `define SCHED_PERF_EN.
module fu_issue_scheduler
  import issue_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [RS_SIZE-1:0]           req_valid,
  input  logic [RS_SIZE-1:0]           req_is_ls,
  output logic [NUM_FU-1:0]            grant_valid,
  output logic [NUM_FU*RS_IDX_W-1:0]   grant_idx,
  output logic [NUM_FU-1:0]            grant_is_ls,
  output logic [RS_SIZE-1:0]           rs_clear,
  output logic [NUM_FU-1:0]            fu_free
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]                  perf_grants,
  output logic [31:0]                  perf_stall
`endif
);
  logic [NUM_FU-1:0]          r_grant_valid;
  logic [NUM_FU*RS_IDX_W-1:0] r_grant_idx;
  logic [NUM_FU-1:0]          r_grant_is_ls;
  logic [RS_SIZE-1:0]         r_rs_clear;
  busy_t                      r_busy [NUM_FU];
  rs_idx_t                    r_rr_ptr;
  fu_id_t                     r_fu_ptr;

  logic [RS_SIZE-1:0] w_elig;
  logic [NUM_FU-1:0]  w_fu_free;
  logic [NUM_FU-1:0]  w_slot_found;
  rs_idx_t            w_slot_idx [NUM_FU];
  fu_id_t             w_slot_fu  [NUM_FU];
  logic [RS_SIZE-1:0] w_clear;

  // Entries cleared last cycle may still read valid; mask them for one cycle
  assign w_elig = req_valid & ~r_rs_clear;

  for (genvar f = 0; f < NUM_FU; f++) begin : g_free
    assign w_fu_free[f] = (r_busy[f] == '0);
  end

  // Selection chain: slot s serves FU (fu_ptr+s) and excludes earlier picks
  for (genvar s = 0; s < NUM_FU; s++) begin : g_slot
    fu_id_t             w_fu;
    logic [RS_SIZE-1:0] w_excl_in;
    logic [RS_SIZE-1:0] w_excl;
    logic [RS_SIZE-1:0] w_excl_out;
    logic [RS_SIZE-1:0] w_vec;
    logic               w_ls_taken;
    logic               w_found;
    rs_idx_t            w_idx;

    if (s == 0) begin : g_head
      assign w_excl_in = '0;
    end else begin : g_link
      assign w_excl_in = g_slot[s-1].w_excl_out;
    end

    assign w_fu       = fu_add(r_fu_ptr, 32'(s));
    assign w_ls_taken = |(w_excl_in & req_is_ls);
    assign w_excl     = w_excl_in | (w_ls_taken ? req_is_ls : '0);
    assign w_vec      = w_fu_free[w_fu] ? w_elig : '0;

    rr_find_first u_find (
      .i_vec   (w_vec),
      .i_start (r_rr_ptr),
      .i_excl  (w_excl),
      .o_found (w_found),
      .o_idx   (w_idx)
    );

    assign w_excl_out      = w_excl_in | (w_found ? (RS_SIZE'(1) << w_idx) : '0);
    assign w_slot_found[s] = w_found;
    assign w_slot_idx[s]   = w_idx;
    assign w_slot_fu[s]    = w_fu;
  end

  assign w_clear = g_slot[NUM_FU-1].w_excl_out;

  logic [NUM_FU-1:0] w_gnt;
  logic [NUM_FU-1:0] w_gnt_ls;
  rs_idx_t           w_gnt_idx [NUM_FU];
  rs_idx_t           w_last;
  logic              w_any;
  rs_idx_t           w_nxt_rr;

  // Map slot picks back onto FUs; last pick in chain order seeds the next scan
  always_comb begin
    w_gnt    = '0;
    w_gnt_ls = '0;
    w_last   = r_rr_ptr;
    for (int unsigned f = 0; f < NUM_FU; f++) w_gnt_idx[f] = '0;
    for (int unsigned s = 0; s < NUM_FU; s++) begin
      if (w_slot_found[s]) begin
        w_gnt[w_slot_fu[s]]     = 1'b1;
        w_gnt_idx[w_slot_fu[s]] = w_slot_idx[s];
        w_gnt_ls[w_slot_fu[s]]  = req_is_ls[w_slot_idx[s]];
        w_last                  = w_slot_idx[s];
      end
    end
  end

  assign w_any    = |w_gnt;
  assign w_nxt_rr = rs_idx_t'((32'(w_last) + 32'd1) % RS_SIZE);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_grant_valid <= '0;
      r_grant_idx   <= '0;
      r_grant_is_ls <= '0;
      r_rs_clear    <= '0;
      r_rr_ptr      <= '0;
      r_fu_ptr      <= '0;
      for (int unsigned f = 0; f < NUM_FU; f++) r_busy[f] <= '0;
    end else begin
      r_grant_valid <= w_gnt;
      r_rs_clear    <= w_clear;
      for (int unsigned f = 0; f < NUM_FU; f++) begin
        if (w_gnt[f]) begin
          r_grant_idx[f*RS_IDX_W +: RS_IDX_W] <= w_gnt_idx[f];
          r_grant_is_ls[f]                    <= w_gnt_ls[f];
          r_busy[f]                           <= busy_load(w_gnt_ls[f]);
        end else if (r_busy[f] != '0) begin
          r_busy[f] <= r_busy[f] - busy_t'(1);
        end
      end
      if (w_any) begin
        r_rr_ptr <= w_nxt_rr;
        r_fu_ptr <= fu_add(r_fu_ptr, 32'd1);
      end
    end
  end

  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;
  assign grant_is_ls = r_grant_is_ls;
  assign rs_clear    = r_rs_clear;
  assign fu_free     = w_fu_free;

`ifdef SCHED_PERF_EN
  logic [31:0] r_perf_grants;
  logic [31:0] r_perf_stall;

  // Counters survive flush; a flushed cycle with eligible work counts as a stall
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_grants <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (!flush) r_perf_grants <= r_perf_grants + 32'($countones(w_gnt));
      if ((|w_elig) && (flush || !w_any)) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_grants = r_perf_grants;
  assign perf_stall  = r_perf_stall;
`endif
endmodule
